// File: rtl/systolic_n_body_state_sequencer_pkg.sv
// Shared types and fixed-point helpers for the n-body state sequencer slice.
// Words are signed Q16.16; the real conversions exist for benches only.
package nbody_pkg;

  localparam int unsigned FX_W    = 32;
  localparam int unsigned FX_FRAC = 16;

  typedef logic signed [FX_W-1:0] fx_t;

  localparam fx_t ONE = 32'h0001_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  function automatic fx_t real_to_fx(input real r);
    real scaled;
    scaled = r * 65536.0;
    return fx_t'($rtoi(scaled + ((scaled >= 0.0) ? 0.5 : -0.5)));
  endfunction

  function automatic real fx_to_real(input fx_t v);
    return $itor(v) / 65536.0;
  endfunction

endpackage

// File: rtl/systolic_n_body_state_sequencer_if.sv
// Bundle of load/acceleration/issue/result/observation signals of the sequencer.
// slave = sequencer side, master = environment (loader, force array, integrator).
interface systolic_n_body_state_sequencer_if #(
  parameter int unsigned N_BODIES = 4,
  parameter int unsigned W        = 32,
  parameter int unsigned IDX_W    = $clog2(N_BODIES)
);
  logic             start;
  logic [W-1:0]     in_dt;
  logic             load_valid;
  logic [IDX_W-1:0] load_idx;
  logic [W-1:0]     load_q_told;
  logic [W-1:0]     load_q_t;
  logic             acc_valid;
  logic [IDX_W-1:0] acc_idx;
  logic [W-1:0]     acc_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [W-1:0]     out_q_i_told;
  logic [W-1:0]     out_q_i_t;
  logic [W-1:0]     out_a_t;
  logic [W-1:0]     out_dt;
  logic             res_valid;
  logic [IDX_W-1:0] res_idx;
  logic [W-1:0]     res_q_i_told;
  logic [W-1:0]     res_q_i_t;
  logic [IDX_W-1:0] rd_idx;
  logic [W-1:0]     rd_q_t;
  logic             busy;
  logic             done;
  logic             acc_dup;

  modport slave (
    input  start, in_dt, load_valid, load_idx, load_q_told, load_q_t,
    input  acc_valid, acc_idx, acc_data, out_ready,
    input  res_valid, res_idx, res_q_i_told, res_q_i_t, rd_idx,
    output out_valid, out_idx, out_q_i_told, out_q_i_t, out_a_t, out_dt,
    output rd_q_t, busy, done, acc_dup
  );

  modport master (
    output start, in_dt, load_valid, load_idx, load_q_told, load_q_t,
    output acc_valid, acc_idx, acc_data, out_ready,
    output res_valid, res_idx, res_q_i_told, res_q_i_t, rd_idx,
    input  out_valid, out_idx, out_q_i_told, out_q_i_t, out_a_t, out_dt,
    input  rd_q_t, busy, done, acc_dup
  );
endinterface

// File: rtl/systolic_n_body_state_sequencer_regfile.sv
// Per-particle storage of {q_told, q_t, a}: one write port per field group,
// combinational reads at the issue pointer and at the observation index.
module nbody_state_regfile
  import nbody_pkg::*;
#(
  parameter int unsigned N_BODIES = 4,
  parameter int unsigned W        = 32,
  parameter int unsigned IDX_W    = $clog2(N_BODIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_q_we,
  input  logic [IDX_W-1:0] i_q_idx,
  input  logic [W-1:0]     i_q_told,
  input  logic [W-1:0]     i_q_t,
  input  logic             i_a_we,
  input  logic [IDX_W-1:0] i_a_idx,
  input  logic [W-1:0]     i_a_data,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [W-1:0]     o_ptr_told,
  output logic [W-1:0]     o_ptr_t,
  output logic [W-1:0]     o_ptr_a,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [W-1:0]     o_rd_q_t
);
  logic [W-1:0] r_told [N_BODIES];
  logic [W-1:0] r_t    [N_BODIES];
  logic [W-1:0] r_a    [N_BODIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BODIES; i++) begin
        r_told[i] <= '0;
        r_t[i]    <= '0;
        r_a[i]    <= '0;
      end
    end else begin
      if (i_q_we) begin
        r_told[i_q_idx] <= i_q_told;
        r_t[i_q_idx]    <= i_q_t;
      end
      if (i_a_we) begin
        r_a[i_a_idx] <= i_a_data;
      end
    end
  end

  assign o_ptr_told = r_told[i_ptr];
  assign o_ptr_t    = r_t[i_ptr];
  assign o_ptr_a    = r_a[i_ptr];
  assign o_rd_q_t   = r_t[i_rd_idx];
endmodule

// File: rtl/systolic_n_body_state_sequencer.sv
// Per-timestep sequencer: gathers accelerations, streams (q_told, q_t, a, dt)
// tuples to the Verlet integrator and writes the returned state back in place.
module systolic_n_body_state_sequencer
  import nbody_pkg::*;
#(
  parameter int unsigned N_BODIES = 4,
  parameter int unsigned W        = 32,
  parameter int unsigned IDX_W    = $clog2(N_BODIES)
) (
  input logic clk,
  input logic rst,
  systolic_n_body_state_sequencer_if.slave bus
);
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(N_BODIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BODIES - 1);

  seq_state_t          r_state;
  logic [W-1:0]        r_dt;
  logic [N_BODIES-1:0] r_mask;
  logic [IDX_W:0]      r_cnt;
  logic [IDX_W-1:0]    r_ptr;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_acc_dup;

  logic                w_load_en;
  logic                w_res_en;
  logic                w_acc_en;
  logic                w_xfer;
  logic                w_q_we;
  logic [IDX_W-1:0]    w_q_idx;
  logic [W-1:0]        w_q_told;
  logic [W-1:0]        w_q_t;
  logic [N_BODIES-1:0] w_acc_bit;
  logic [IDX_W:0]      w_cnt_nxt;
  logic                w_cnt_full;
  logic [W-1:0]        w_ptr_told;
  logic [W-1:0]        w_ptr_t;
  logic [W-1:0]        w_ptr_a;

  assign w_load_en = (r_state == S_IDLE) && bus.load_valid;
  assign w_acc_en  = (r_state == S_GATHER) && bus.acc_valid;
  assign w_res_en  = bus.res_valid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_xfer    = r_out_valid && bus.out_ready;

  // Loads and results never coincide: loads only in IDLE, results only in ISSUE/DRAIN.
  assign w_q_we   = w_load_en || w_res_en;
  assign w_q_idx  = w_res_en ? bus.res_idx      : bus.load_idx;
  assign w_q_told = w_res_en ? bus.res_q_i_told : bus.load_q_told;
  assign w_q_t    = w_res_en ? bus.res_q_i_t    : bus.load_q_t;

  always_comb begin
    w_acc_bit = '0;
    w_acc_bit[bus.acc_idx] = 1'b1;
    w_cnt_nxt = r_cnt;
    if (w_res_en && (r_cnt != CNT_FULL)) w_cnt_nxt = r_cnt + 1'b1;
  end

  // Count including this cycle's result, so done follows the final result by one cycle.
  assign w_cnt_full = (w_cnt_nxt == CNT_FULL);

  nbody_state_regfile #(
    .N_BODIES (N_BODIES),
    .W        (W),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_q_we     (w_q_we),
    .i_q_idx    (w_q_idx),
    .i_q_told   (w_q_told),
    .i_q_t      (w_q_t),
    .i_a_we     (w_acc_en),
    .i_a_idx    (bus.acc_idx),
    .i_a_data   (bus.acc_data),
    .i_ptr      (r_ptr),
    .o_ptr_told (w_ptr_told),
    .o_ptr_t    (w_ptr_t),
    .o_ptr_a    (w_ptr_a),
    .i_rd_idx   (bus.rd_idx),
    .o_rd_q_t   (bus.rd_q_t)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dt        <= '0;
      r_mask      <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_acc_dup   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dt      <= bus.in_dt;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_acc_dup <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_GATHER;
          end
        end
        S_GATHER: begin
          if (w_acc_en) begin
            r_mask <= r_mask | w_acc_bit;
            if (r_mask[bus.acc_idx]) r_acc_dup <= 1'b1;
          end
          if (&r_mask) begin
            r_out_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_xfer) begin
            if (r_ptr == LAST_IDX) begin
              r_out_valid <= 1'b0;
              r_ptr       <= '0;
              if (w_cnt_full) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_DRAIN;
              end
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_cnt_full) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.out_idx      = r_ptr;
  assign bus.out_q_i_told = w_ptr_told;
  assign bus.out_q_i_t    = w_ptr_t;
  assign bus.out_a_t      = w_ptr_a;
  assign bus.out_dt       = r_dt;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.acc_dup      = r_acc_dup;
endmodule

// File: tb/tb_systolic_n_body_state_sequencer.sv
// Bench for the n-body state sequencer: behavioural particle model plus a
// Verlet integrator that answers issued tuples after a random delay.
module tb_systolic_n_body_state_sequencer;
  import nbody_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_n_body_state_sequencer_if #(.N_BODIES(N), .W(32), .IDX_W(2)) bus ();

  systolic_n_body_state_sequencer #(.N_BODIES(N), .W(32), .IDX_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_told [N];
  logic [31:0] m_t    [N];
  logic [31:0] m_a    [N];
  logic [31:0] e_told [N];
  logic [31:0] e_t    [N];
  logic [31:0] e_a    [N];

  int          o_idx  [$];
  logic [31:0] o_told [$];
  logic [31:0] o_t    [$];
  logic [31:0] o_a    [$];
  logic [31:0] o_dt   [$];
  int          p_idx  [$];
  int          p_due  [$];
  logic [31:0] p_told [$];
  logic [31:0] p_t    [$];
  int          stall_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_fx();
    return 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000;
  endfunction

  task automatic do_load(input int idx, input logic [31:0] told, input logic [31:0] t);
    bus.load_valid = 1'b1; bus.load_idx = 2'(idx);
    bus.load_q_told = told; bus.load_q_t = t;
    tick();
    bus.load_valid = 1'b0;
    m_told[idx] = told; m_t[idx] = t;
  endtask

  task automatic do_start(input logic [31:0] dt);
    bus.start = 1'b1; bus.in_dt = dt;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_acc(input int idx, input logic [31:0] a);
    bus.acc_valid = 1'b1; bus.acc_idx = 2'(idx); bus.acc_data = a;
    tick();
    bus.acc_valid = 1'b0;
    m_a[idx] = a;
  endtask

  task automatic snapshot();
    for (int i = 0; i < N; i++) begin
      e_told[i] = m_told[i]; e_t[i] = m_t[i]; e_a[i] = m_a[i];
    end
  endtask

  // Handles ISSUE and DRAIN: records transfers, returns Verlet results; stops on
  // done, after max_res results when fewer than N, or on cycle budget expiry.
  task automatic drain(input int mode, input int max_res, output int n_done,
                       output bit last_done_ok, output bit timeout);
    int cyc = 0;
    int nres = 0;
    bit pv = 0, pr = 0, fin = 0, rv;
    logic [31:0] h_told = '0, h_t = '0, h_a = '0, h_dt = '0;
    logic [1:0]  h_idx = '0;
    longint lo, lt, la, ld, adt;
    o_idx.delete(); o_told.delete(); o_t.delete(); o_a.delete(); o_dt.delete();
    p_idx.delete(); p_due.delete(); p_told.delete(); p_t.delete();
    stall_err = 0; n_done = 0; last_done_ok = 0; timeout = 0;
    while (!fin) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      rv = 0;
      if (p_idx.size() > 0 && p_due[0] <= cyc && nres < max_res) begin
        bus.res_valid = 1'b1; bus.res_idx = 2'(p_idx[0]);
        bus.res_q_i_told = p_told[0]; bus.res_q_i_t = p_t[0];
        m_told[p_idx[0]] = p_told[0]; m_t[p_idx[0]] = p_t[0];
        void'(p_idx.pop_front()); void'(p_due.pop_front());
        void'(p_told.pop_front()); void'(p_t.pop_front());
        nres++; rv = 1;
      end else begin
        bus.res_valid = 1'b0;
      end
      if (bus.out_valid) begin
        if (pv && !pr && (bus.out_idx !== h_idx || bus.out_q_i_told !== h_told ||
            bus.out_q_i_t !== h_t || bus.out_a_t !== h_a || bus.out_dt !== h_dt))
          stall_err++;
        h_idx = bus.out_idx; h_told = bus.out_q_i_told; h_t = bus.out_q_i_t;
        h_a = bus.out_a_t; h_dt = bus.out_dt;
        if (bus.out_ready) begin
          o_idx.push_back(int'(bus.out_idx)); o_told.push_back(h_told);
          o_t.push_back(h_t); o_a.push_back(h_a); o_dt.push_back(h_dt);
          lo = longint'($signed(h_told)); lt = longint'($signed(h_t));
          la = longint'($signed(h_a));    ld = longint'($signed(h_dt));
          adt = (((la * ld) >>> 16) * ld) >>> 16;
          p_idx.push_back(int'(bus.out_idx)); p_due.push_back(cyc + 1 + int'($urandom_range(0, 2)));
          p_told.push_back(h_t); p_t.push_back(32'(2 * lt - lo + adt));
        end
      end
      pv = bus.out_valid; pr = bus.out_ready;
      tick();
      cyc++;
      if (bus.done) n_done++;
      if (rv && nres == N) last_done_ok = bus.done;
      if (n_done > 0) fin = 1;
      if (max_res < N && nres == max_res) fin = 1;
      if (cyc > 300) begin timeout = 1; fin = 1; end
    end
    bus.res_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if ({bus.busy, bus.done, bus.out_valid, bus.acc_dup} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.busy, bus.done, bus.out_valid, bus.acc_dup});
    end
    n_tests++;
    if ({bus.out_idx, bus.out_q_i_told, bus.out_q_i_t, bus.out_a_t, bus.out_dt} !== '0) begin
      n_fail++; $display("FAIL reset_out_data: got nonzero expected 0 (told=%h dt=%h)", bus.out_q_i_told, bus.out_dt);
    end
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 2'(i); #1;
      n_tests++;
      if (bus.rd_q_t !== 32'h0) begin
        n_fail++; $display("FAIL reset_rd_q_t[%0d]: got %h expected 0", i, bus.rd_q_t);
      end
      m_told[i] = '0; m_t[i] = '0; m_a[i] = '0;
    end
  endtask

  task automatic test_single_body();
    int nd; bit ldok, to;
    logic [31:0] dt;
    dt = real_to_fx(0.1);
    do_load(0, real_to_fx(1.5), real_to_fx(4.0));
    for (int i = 1; i < N; i++) do_load(i, rnd_fx(), rnd_fx());
    do_start(dt);
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b expected 1", bus.busy); end
    send_acc(0, ONE);
    for (int i = 1; i < N; i++) send_acc(i, rnd_fx());
    snapshot();
    drain(0, N, nd, ldok, to);
    n_tests++;
    if (to || nd != 1 || !ldok) begin
      n_fail++; $display("FAIL single_done: got timeout=%0d done=%0d done_after_last=%0d expected 0 1 1", to, nd, ldok);
    end
    n_tests++;
    if (o_idx.size() != N || o_idx[0] != 0 || o_told[0] !== 32'h0001_8000 || o_t[0] !== 32'h0004_0000 ||
        o_a[0] !== 32'h0001_0000 || o_dt[0] !== 32'h0000_199A) begin
      n_fail++; $display("FAIL single_tuple0: got n=%0d told=%h t=%h a=%h dt=%h expected 4 00018000 00040000 00010000 0000199a",
                         o_idx.size(), o_told[0], o_t[0], o_a[0], o_dt[0]);
    end
    for (int k = 0; k < o_idx.size(); k++) begin
      n_tests++;
      if (o_idx[k] != k || o_told[k] !== e_told[k] || o_t[k] !== e_t[k] || o_a[k] !== e_a[k]) begin
        n_fail++; $display("FAIL single_tuple[%0d]: got idx=%0d %h %h %h expected %0d %h %h %h",
                           k, o_idx[k], o_told[k], o_t[k], o_a[k], k, e_told[k], e_t[k], e_a[k]);
      end
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL done_one_cycle: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
    bus.rd_idx = 2'd0; #1;
    n_tests++;
    if (bus.rd_q_t !== real_to_fx(6.51)) begin
      n_fail++; $display("FAIL single_rd_q_t: got %h expected %h", bus.rd_q_t, real_to_fx(6.51));
    end
  endtask

  task automatic test_out_of_order();
    int nd; bit ldok, to;
    do_start(rnd_fx());
    send_acc(3, rnd_fx()); send_acc(1, rnd_fx()); send_acc(0, rnd_fx()); send_acc(2, rnd_fx());
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_valid_g1: got %b expected 0", bus.out_valid); end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ooo_valid_g2: got %b expected 1", bus.out_valid); end
    snapshot();
    drain(0, N, nd, ldok, to);
    n_tests++;
    if (to || nd != 1 || o_idx.size() != N) begin
      n_fail++; $display("FAIL ooo_count: got timeout=%0d done=%0d xfers=%0d expected 0 1 4", to, nd, o_idx.size());
    end
    for (int k = 0; k < o_idx.size(); k++) begin
      n_tests++;
      if (o_idx[k] != k || o_a[k] !== e_a[k]) begin
        n_fail++; $display("FAIL ooo_order[%0d]: got idx=%0d a=%h expected %0d %h", k, o_idx[k], o_a[k], k, e_a[k]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int nd; bit ldok, to;
    do_start(rnd_fx());
    for (int i = 0; i < N; i++) send_acc(i, rnd_fx());
    snapshot();
    tick();
    drain(1, N, nd, ldok, to);
    n_tests++;
    if (to || nd != 1 || o_idx.size() != N || stall_err != 0) begin
      n_fail++; $display("FAIL bp_count: got timeout=%0d done=%0d xfers=%0d stall_err=%0d expected 0 1 4 0",
                         to, nd, o_idx.size(), stall_err);
    end
    for (int k = 0; k < o_idx.size(); k++) begin
      n_tests++;
      if (o_idx[k] != k || o_told[k] !== e_told[k] || o_t[k] !== e_t[k] || o_a[k] !== e_a[k]) begin
        n_fail++; $display("FAIL bp_tuple[%0d]: got idx=%0d %h %h %h expected %0d %h %h %h",
                           k, o_idx[k], o_told[k], o_t[k], o_a[k], k, e_told[k], e_t[k], e_a[k]);
      end
    end
    tick();
  endtask

  task automatic test_duplicate_acc();
    int nd; bit ldok, to;
    do_start(rnd_fx());
    send_acc(1, 32'h0002_0000); send_acc(1, 32'h0003_0000);
    n_tests++;
    if (bus.acc_dup !== 1'b1) begin n_fail++; $display("FAIL dup_flag: got %b expected 1", bus.acc_dup); end
    send_acc(0, rnd_fx()); send_acc(3, rnd_fx());
    tick(); tick(); tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL dup_wait: got out_valid=%b busy=%b expected 0 1", bus.out_valid, bus.busy);
    end
    send_acc(2, rnd_fx());
    drain(0, N, nd, ldok, to);
    n_tests++;
    if (to || o_idx.size() != N || o_a[1] !== 32'h0003_0000 || bus.acc_dup !== 1'b1) begin
      n_fail++; $display("FAIL dup_a1: got xfers=%0d a1=%h dup=%b expected 4 00030000 1",
                         o_idx.size(), (o_a.size() > 1) ? o_a[1] : 32'hx, bus.acc_dup);
    end
    tick();
  endtask

  task automatic test_ignored_controls();
    int nd; bit ldok, to;
    logic [31:0] dt1;
    dt1 = rnd_fx();
    do_start(dt1);
    n_tests++;
    if (bus.acc_dup !== 1'b0) begin n_fail++; $display("FAIL dup_cleared: got %b expected 0", bus.acc_dup); end
    send_acc(0, rnd_fx()); send_acc(1, rnd_fx());
    bus.start = 1'b1; bus.in_dt = ~dt1;
    bus.load_valid = 1'b1; bus.load_idx = 2'd2; bus.load_q_told = ~m_told[2]; bus.load_q_t = ~m_t[2];
    tick();
    bus.start = 1'b0; bus.load_valid = 1'b0;
    bus.rd_idx = 2'd2; #1;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.rd_q_t !== m_t[2]) begin
      n_fail++; $display("FAIL ign_load: got busy=%b rd_q_t=%h expected 1 %h", bus.busy, bus.rd_q_t, m_t[2]);
    end
    send_acc(2, rnd_fx()); send_acc(3, rnd_fx());
    snapshot();
    drain(2, N, nd, ldok, to);
    for (int k = 0; k < o_idx.size(); k++) begin
      n_tests++;
      if (o_dt[k] !== dt1 || o_told[k] !== e_told[k] || o_t[k] !== e_t[k]) begin
        n_fail++; $display("FAIL ign_tuple[%0d]: got dt=%h told=%h t=%h expected %h %h %h",
                           k, o_dt[k], o_told[k], o_t[k], dt1, e_told[k], e_t[k]);
      end
    end
    n_tests++;
    if (to || nd != 1 || o_idx.size() != N) begin
      n_fail++; $display("FAIL ign_count: got timeout=%0d done=%0d xfers=%0d expected 0 1 4", to, nd, o_idx.size());
    end
    tick();
  endtask

  task automatic test_random_steps();
    int nd; bit ldok, to;
    int perm [N];
    int j, tmp;
    logic [31:0] dt;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) do_load(i, rnd_fx(), rnd_fx());
      dt = 32'($urandom_range(0, 32'h0001_0000));
      do_start(dt);
      for (int i = 0; i < N; i++) perm[i] = i;
      for (int i = N - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i)); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int i = 0; i < N; i++) send_acc(perm[i], rnd_fx());
      snapshot();
      drain(2, N, nd, ldok, to);
      n_tests++;
      if (to || nd != 1 || !ldok || o_idx.size() != N || stall_err != 0) begin
        n_fail++; $display("FAIL rnd_step%0d: got timeout=%0d done=%0d done_after_last=%0d xfers=%0d stall=%0d expected 0 1 1 4 0",
                           s, to, nd, ldok, o_idx.size(), stall_err);
      end
      for (int k = 0; k < o_idx.size(); k++) begin
        n_tests++;
        if (o_idx[k] != k || o_told[k] !== e_told[k] || o_t[k] !== e_t[k] || o_a[k] !== e_a[k] || o_dt[k] !== dt) begin
          n_fail++; $display("FAIL rnd_tuple%0d[%0d]: got idx=%0d %h %h %h %h expected %0d %h %h %h %h",
                             s, k, o_idx[k], o_told[k], o_t[k], o_a[k], o_dt[k], k, e_told[k], e_t[k], e_a[k], dt);
        end
      end
      tick();
      for (int i = 0; i < N; i++) begin
        bus.rd_idx = 2'(i); #1;
        n_tests++;
        if (bus.rd_q_t !== m_t[i]) begin
          n_fail++; $display("FAIL rnd_rd%0d[%0d]: got %h expected %h", s, i, bus.rd_q_t, m_t[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int nd; bit ldok, to;
    for (int i = 0; i < N; i++) do_load(i, rnd_fx(), rnd_fx() | 32'h0010_0000);
    do_start(rnd_fx());
    for (int i = 0; i < N; i++) send_acc(i, rnd_fx());
    drain(0, 2, nd, ldok, to);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (to || nd != 0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got timeout=%0d done_pulses=%0d busy=%b done=%b out_valid=%b expected 0 0 0 0 0",
                         to, nd, bus.busy, bus.done, bus.out_valid);
    end
    for (int i = 0; i < N; i++) begin
      bus.rd_idx = 2'(i); #1;
      n_tests++;
      if (bus.rd_q_t !== 32'h0) begin
        n_fail++; $display("FAIL rst_mid_rd[%0d]: got %h expected 0", i, bus.rd_q_t);
      end
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_dt = '0;
    bus.load_valid = 1'b0; bus.load_idx = '0; bus.load_q_told = '0; bus.load_q_t = '0;
    bus.acc_valid = 1'b0; bus.acc_idx = '0; bus.acc_data = '0;
    bus.out_ready = 1'b0;
    bus.res_valid = 1'b0; bus.res_idx = '0; bus.res_q_i_told = '0; bus.res_q_i_t = '0;
    bus.rd_idx = '0;
    test_reset();
    test_single_body();
    test_out_of_order();
    test_backpressure();
    test_duplicate_acc();
    test_ignored_controls();
    test_random_steps();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_n_body_state_sequencer.md
# systolic_n_body_state_sequencer

Per-timestep state sequencer at the far end of the Verlet integration interface. It holds every particle's `q_i_told` and `q_i_t` in a register file and gathers each particle's acceleration from the force array. It then streams (`q_i_told`, `q_i_t`, `a_t`, `dt`) tuples to the integration cell under a valid/ready handshake, and writes the returned (`q_i_told`, `q_i_t`) back in place. One `start` pulse advances all bodies by one timestep.

## Interface

Parameters:
- `N_BODIES`, 4: number of particles; ≥ 2.
- `W`, 32: signed fixed-point word width, Q(W-16).16.
- `IDX_W`, `$clog2(N_BODIES)`: particle index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a timestep; honoured only in IDLE.
- `in_dt` in W: timestep; latched when `start` is accepted.
- `load_valid` in 1, `load_idx` in IDX_W, `load_q_told` in W, `load_q_t` in W: initial-state write; honoured only in IDLE.
- `acc_valid` in 1, `acc_idx` in IDX_W, `acc_data` in W: acceleration from the force array; any order, one per particle per step.
- `out_valid` out 1, `out_ready` in 1: issue handshake to the integrator.
- `out_idx` out IDX_W, `out_q_i_told` out W, `out_q_i_t` out W, `out_a_t` out W, `out_dt` out W: issued tuple.
- `res_valid` in 1, `res_idx` in IDX_W, `res_q_i_told` in W, `res_q_i_t` in W: integrator result; always accepted, no backpressure.
- `rd_idx` in IDX_W, `rd_q_t` out W: combinational observation port.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at end of a step.
- `acc_dup` out 1: sticky error, set by a duplicate acceleration index within a step; cleared by accepted `start` or by `rst`.

## Operation

States: IDLE → GATHER → ISSUE → DRAIN → DONE → IDLE.

- **IDLE**
  - `load_valid` writes both words at `load_idx`.
  - `start` latches `dt`, clears the acceleration mask, result count and `acc_dup`, then moves to GATHER.
  - If `load_valid` and `start` occur in the same cycle, the load is written and the start is taken.
- **GATHER**
  - `acc_valid` stores `acc_data` at `acc_idx` and sets mask bit `acc_idx`.
  - If that mask bit is already set: the data is overwritten, `acc_dup` is set, and the mask is unchanged.
  - Leaves for ISSUE the cycle after the mask becomes all-ones.
  - `acc_valid` outside GATHER is ignored.
- **ISSUE**
  - Issue pointer runs 0..N_BODIES-1.
  - `out_valid`=1; the tuple is read from the pointer entry.
  - On `out_valid && out_ready` the pointer increments.
  - After the last transfer the FSM goes to DRAIN; if the result count already equals N_BODIES, it goes straight to DONE.
- **Results**
  - Accepted in ISSUE and DRAIN. `res_valid` overwrites entry `res_idx` and increments the result count.
  - If a result targets the entry being presented in the same cycle, the presented tuple keeps the pre-write values, because reads are combinational from registers before the update.
  - `res_valid` in IDLE, GATHER or DONE is ignored.
- **DRAIN**: when the result count reaches N_BODIES, the FSM goes to DONE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- `load_valid` and `start` are ignored while `busy`.
- **Arithmetic**: none inside the block; words are passed through unmodified. The result count is IDX_W+1 bits wide and saturates at N_BODIES.

## Timing

- **Reset values**:
  - state IDLE
  - all register-file entries 0, including accelerations and the latched `dt`
  - `out_valid`=0, `busy`=0, `done`=0, `acc_dup`=0
  - `out_*` data = 0
  - issue pointer = 0, result count = 0
- **`rst` mid-step**: aborts the step next edge. No `done` is emitted, and positions are cleared to 0.
- **Latency**:
  - `start` accepted at edge k ⇒ `busy`=1 from cycle k+1.
  - Last mask bit set at edge g ⇒ `out_valid`=1 from cycle g+2.
  - With `out_ready` held high, one tuple issues per cycle.
  - Final result accepted at edge r ⇒ `done`=1 in cycle r+1, and IDLE from r+2.
- **Handshake**: while `out_valid && !out_ready`, all `out_*` are held stable. `out_valid` never drops without a transfer.
- `rd_q_t` is combinational from the register file and reflects writes the cycle after they occur.

## Structure

- Shared package `nbody_pkg`:
  - fixed-point word typedef (`W`, 16 fractional bits)
  - state enum `seq_state_t`
  - fixed-point constants ONE (`32'h0001_0000`) and a `real`↔fixed conversion function for benches
- One sub-module: `nbody_state_regfile`, holding N_BODIES × {q_told, q_t, a}. It has one write port per field group and combinational reads at the issue pointer and at `rd_idx`.

## Test plan

- **Single body**: load idx0 told=1.5, t=4.0; `start` with dt=0.1; acc idx0=1.0.
  - Expect tuple (1.5, 4.0, 1.0, 0.1) on idx0.
  - Bench integrator returns (4.0, 6.51) ⇒ after `done`, `rd_q_t`(0)=6.51 in fixed point.
- **Out-of-order gather**: N=4, accelerations arrive as idx 3, 1, 0, 2 ⇒ issue order is 0, 1, 2, 3 with matching `out_a_t`; `out_valid` rises 2 cycles after idx2 arrives.
- **Backpressure**: `out_ready` toggles 1,0,0,1,… ⇒ exactly 4 transfers, `out_*` stable during stalls, no tuple skipped or repeated.
- **Duplicate acceleration**: idx1 sent twice (2.0 then 3.0) ⇒ `acc_dup`=1, stays in GATHER until the missing index arrives, issued `a_t` for idx1 = 3.0.
- **Ignored controls**: `start` and `load_valid` pulsed mid-GATHER ⇒ no state change, register file unchanged.
- **Reset mid-DRAIN**: `rst` asserted after 2 of 4 results ⇒ next cycle IDLE, `busy`=0, `rd_q_t`=0 for all idx, no `done` pulse.
